// File: rtl/display_pkg.sv
// Shared constants for the display source scheduler: FSM encodings and the
// driver's signed 8-bit range.
package display_pkg;

   localparam logic [1:0] ST_MANUAL = 2'd0;
   localparam logic [1:0] ST_AUTO   = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam int          SAT_MAX = 127;
   localparam int          SAT_MIN = -128;
   localparam int unsigned DISP_W  = 13;

endpackage

// File: rtl/signed_saturator.sv
// Clips a signed DW-bit word to the signed 8-bit display range and flags clipping.
module signed_saturator
   import display_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic [DW-1:0] value,
   output logic [7:0]    value_c,
   output logic          clipped_c
);

   localparam logic signed [DW-1:0] MAX_V = DW'(SAT_MAX);
   localparam logic signed [DW-1:0] MIN_V = DW'(SAT_MIN);

   always_comb begin
      value_c   = value[7:0];
      clipped_c = 1'b0;
      if ($signed(value) > MAX_V) begin
         value_c   = 8'h7F;
         clipped_c = 1'b1;
      end else if ($signed(value) < MIN_V) begin
         value_c   = 8'h80;
         clipped_c = 1'b1;
      end
   end

endmodule

// File: rtl/display_source_scheduler.sv
// Picks one datapath word for the 7-segment driver: manual select, timed
// auto-rotation, or a frozen hold with single-step.
module display_source_scheduler
   import display_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned DW           = 32,
   parameter int unsigned DWELL_CYCLES = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC*DW-1:0] src_data,
   input  logic                  mode_auto,
   input  logic [1:0]            sel,
   input  logic                  hold_btn,
   input  logic                  step_btn,
   output logic [DISP_W-1:0]     num,
   output logic [1:0]            src_idx,
   output logic                  sat_flag,
   output logic                  held
);

   localparam int unsigned     CW         = $clog2(DWELL_CYCLES);
   localparam logic [1:0]      LAST_IDX   = 2'(NUM_SRC - 1);
   localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL_CYCLES - 1);

   logic [1:0]    state, state_n;
   logic [1:0]    idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          step_pend, step_pend_n;
   logic          hold_q, step_q;
   logic          hold_edge, step_edge;
   logic          sample;
   logic [1:0]    sel_c;
   logic [DW-1:0] src_word;
   logic [7:0]    value_c;
   logic          clipped_c;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
   endfunction

   assign hold_edge = hold_btn & ~hold_q;
   assign step_edge = step_btn & ~step_q;
   assign sel_c     = (32'(sel) >= NUM_SRC) ? LAST_IDX : sel;
   assign src_word  = src_data[int'(src_idx)*DW +: DW];
   // HOLD freezes the output except for the single re-sample after a step
   assign sample    = (state != ST_HOLD) || step_pend;

   signed_saturator #(.DW(DW)) u_sat (
      .value     (src_word),
      .value_c   (value_c),
      .clipped_c (clipped_c)
   );

   // Next-state logic; hold edges take priority over steps and dwell expiry
   always_comb begin
      state_n     = state;
      idx_n       = src_idx;
      cnt_n       = cnt;
      step_pend_n = 1'b0;
      case (state)
         ST_MANUAL: begin
            cnt_n = '0;
            if (hold_edge)      state_n = ST_HOLD;
            else if (mode_auto) state_n = ST_AUTO;
            else                idx_n   = sel_c;
         end
         ST_AUTO: begin
            if (hold_edge) begin
               state_n = ST_HOLD;
            end else if (!mode_auto) begin
               state_n = ST_MANUAL;
               cnt_n   = '0;
            end else if (cnt == DWELL_LAST) begin
               cnt_n = '0;
               idx_n = next_idx(src_idx);
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_HOLD: begin
            if (hold_edge) begin
               state_n = mode_auto ? ST_AUTO : ST_MANUAL;
               cnt_n   = '0;
            end else if (step_edge) begin
               idx_n       = next_idx(src_idx);
               step_pend_n = 1'b1;
            end
         end
         default: begin
            state_n = ST_MANUAL;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_MANUAL;
         src_idx   <= 2'd0;
         cnt       <= '0;
         step_pend <= 1'b0;
         hold_q    <= 1'b1;
         step_q    <= 1'b1;
         num       <= '0;
         sat_flag  <= 1'b0;
         held      <= 1'b0;
      end else begin
         state     <= state_n;
         src_idx   <= idx_n;
         cnt       <= cnt_n;
         step_pend <= step_pend_n;
         hold_q    <= hold_btn;
         step_q    <= step_btn;
         held      <= (state_n == ST_HOLD);
         if (sample) begin
            num      <= {{(DISP_W - 8){value_c[7]}}, value_c};
            sat_flag <= clipped_c;
         end
      end
   end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with a short dwell (4 cycles).
module tb_display_source_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] src_data;
   logic         mode_auto;
   logic [1:0]   sel;
   logic         hold_btn;
   logic         step_btn;
   logic [12:0]  num;
   logic [1:0]   src_idx;
   logic         sat_flag;
   logic         held;

   logic [31:0]  src [4];
   int           checks = 0;
   int           errors = 0;

   assign src_data = {src[3], src[2], src[1], src[0]};

   always #5 clk = ~clk;

   display_source_scheduler #(.NUM_SRC(4), .DW(32), .DWELL_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_data  (src_data),
      .mode_auto (mode_auto),
      .sel       (sel),
      .hold_btn  (hold_btn),
      .step_btn  (step_btn),
      .num       (num),
      .src_idx   (src_idx),
      .sat_flag  (sat_flag),
      .held      (held)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_idx(input string name, input logic [1:0] exp);
      checks++;
      if (src_idx !== exp) begin
         errors++;
         $display("FAIL %s src_idx got %0d exp %0d", name, src_idx, exp);
      end
   endtask

   task automatic chk_num(input string name, input logic [12:0] exp, input logic exp_sat);
      checks++;
      if (num !== exp || sat_flag !== exp_sat) begin
         errors++;
         $display("FAIL %s num/sat got %h/%b exp %h/%b", name, num, sat_flag, exp, exp_sat);
      end
   endtask

   task automatic chk_held(input string name, input logic exp);
      checks++;
      if (held !== exp) begin
         errors++;
         $display("FAIL %s held got %b exp %b", name, held, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; hold_btn = 1'b1; step_btn = 1'b0; mode_auto = 1'b0; sel = 2'd0;
      for (int i = 0; i < 4; i++) src[i] = 32'd0;
      tick(3);
      rst = 1'b0;
      chk_num("reset_num", 13'h0000, 1'b0);
      chk_idx("reset_idx", 2'd0);
      chk_held("reset_held", 1'b0);
      tick(3);
      chk_held("reset_no_hold_entry", 1'b0);
      chk_idx("reset_idx_after", 2'd0);
      hold_btn = 1'b0;
      tick(1);
   endtask

   task automatic test_manual;
      sel = 2'd2; src[2] = -32'sd5;
      tick(1);
      chk_idx("manual_sel2", 2'd2);
      tick(1);
      chk_num("manual_neg5", 13'h1FFB, 1'b0);
      sel = 2'd3;
      tick(1);
      chk_idx("manual_sel3", 2'd3);
   endtask

   task automatic test_saturation;
      sel = 2'd1; src[1] = 32'd300;
      tick(2);
      chk_num("sat_300", 13'h007F, 1'b1);
      src[1] = -32'sd129;
      tick(1);
      chk_num("sat_neg129", 13'h1F80, 1'b1);
      src[1] = -32'sd128;
      tick(1);
      chk_num("sat_neg128", 13'h1F80, 1'b0);
      src[1] = 32'd127;
      tick(1);
      chk_num("sat_127", 13'h007F, 1'b0);
      src[1] = 32'h8000_0000;
      tick(1);
      chk_num("sat_min_int", 13'h1F80, 1'b1);
   endtask

   task automatic test_auto;
      logic [12:0] exp_num [4];
      exp_num[0] = 13'h000A; exp_num[1] = 13'h0014;
      exp_num[2] = 13'h1FE2; exp_num[3] = 13'h0028;
      src[0] = 32'd10; src[1] = 32'd20; src[2] = -32'sd30; src[3] = 32'd40;
      sel = 2'd0;
      tick(2);
      chk_idx("auto_start", 2'd0);
      mode_auto = 1'b1;
      tick(1);
      for (int k = 1; k <= 4; k++) begin
         tick(3);
         chk_idx("auto_dwell", 2'((k - 1) % 4));
         chk_num("auto_num", exp_num[(k - 1) % 4], 1'b0);
         tick(1);
         chk_idx("auto_advance", 2'(k % 4));
      end
   endtask

   task automatic test_hold_step;
      tick(4);
      chk_idx("hold_pre", 2'd1);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0;
      chk_held("hold_enter", 1'b1);
      chk_num("hold_enter_num", 13'h0014, 1'b0);
      src[1] = 32'd99;
      tick(3);
      chk_num("hold_frozen_num", 13'h0014, 1'b0);
      chk_idx("hold_frozen_idx", 2'd1);
      step_btn = 1'b1;
      tick(1);
      step_btn = 1'b0;
      chk_idx("step_idx", 2'd2);
      chk_num("step_num_lag", 13'h0014, 1'b0);
      tick(1);
      chk_num("step_num", 13'h1FE2, 1'b0);
      src[2] = -32'sd200;
      tick(1);
      chk_num("step_once", 13'h1FE2, 1'b0);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0;
      chk_held("hold_exit", 1'b0);
      tick(1);
      chk_num("exit_resample", 13'h1F80, 1'b1);
      tick(2);
      chk_idx("exit_cnt_zero", 2'd2);
      tick(1);
      chk_idx("exit_advance", 2'd3);
   endtask

   task automatic test_simultaneous;
      mode_auto = 1'b0; sel = 2'd3;
      tick(2);
      chk_idx("sim_manual", 2'd3);
      hold_btn = 1'b1; step_btn = 1'b1;
      tick(1);
      chk_held("sim_hold_step_held", 1'b1);
      chk_idx("sim_hold_step_idx", 2'd3);
      tick(2);
      chk_idx("sim_levels_no_edge", 2'd3);
      hold_btn = 1'b0; step_btn = 1'b0;
      tick(1);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0;
      chk_held("sim_exit_manual", 1'b0);
      tick(1);
      mode_auto = 1'b1;
      tick(1);
      tick(3);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0;
      chk_held("sim_dwell_hold", 1'b1);
      chk_idx("sim_dwell_no_adv", 2'd3);
      tick(2);
      chk_idx("sim_dwell_frozen", 2'd3);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0; step_btn = 1'b1;
      tick(1);
      step_btn = 1'b0;
      chk_idx("step_outside_hold", 2'd3);
      chk_held("step_outside_held", 1'b0);
      tick(2);
      chk_idx("resume_dwell", 2'd3);
      tick(1);
      chk_idx("resume_wrap", 2'd0);
      hold_btn = 1'b1;
      tick(1);
      hold_btn = 1'b0;
      chk_held("rst_pre_hold", 1'b1);
      mode_auto = 1'b0; sel = 2'd2;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_held("rst_hold_held", 1'b0);
      chk_idx("rst_hold_idx", 2'd0);
      chk_num("rst_hold_num", 13'h0000, 1'b0);
      tick(1);
      chk_idx("rst_to_manual", 2'd2);
   endtask

   initial begin
      test_reset();
      test_manual();
      test_saturation();
      test_auto();
      test_hold_step();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
